// File: rtl/fbc_multi_cache.sv
// fbc_multi_cache: gathers one sample per enabled channel during a scan, tags it with encoder
// position and sequence number, and streams packed records out through a FIFO and output register.
module fbc_multi_cache #(
  parameter int CH_NUM  = 4,
  parameter int CH_W    = 48,
  parameter int ENC_W   = 18,
  parameter int OUT_W   = 256,
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     scan_flag_i,
  input  logic [CH_NUM-1:0]        ch_en_i,
  input  logic [CH_NUM-1:0]        ch_vld_i,
  input  logic [CH_NUM*CH_W-1:0]   ch_data_i,
  input  logic [31:0]              encode_w_i,
  input  logic [31:0]              encode_x_i,
  output logic                     out_vld_o,
  output logic [OUT_W-1:0]         out_data_o,
  input  logic                     out_rdy_i,
  output logic [15:0]              overflow_cnt_o,
  output logic [15:0]              timeout_cnt_o,
  output logic                     busy_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CB = 16 + 2 * ENC_W;

  logic              r_scan_d;
  logic [CH_NUM-1:0] r_en, r_rdy;
  logic [CH_W-1:0]   r_data [CH_NUM];
  logic [ENC_W-1:0]  r_enc_w, r_enc_x;
  logic [TW-1:0]     r_tcnt;
  logic [7:0]        r_seq;
  logic [AW:0]       r_wp, r_rp;
  logic [OUT_W-1:0]  r_mem [DEPTH];
  logic              r_out_vld;
  logic [OUT_W-1:0]  r_out_data;
  logic [15:0]       r_ovf, r_tmo;

  logic              w_rise, w_any, w_complete, w_tmo, w_flush, w_commit, w_first;
  logic [CH_NUM-1:0] w_acc;
  logic              w_empty, w_full, w_take, w_pop, w_bypass, w_push, w_drop;
  logic [OUT_W-1:0]  w_rec;
  logic              w_unused;

  assign w_unused   = ^{encode_w_i[31:ENC_W], encode_x_i[31:ENC_W]};
  assign w_rise     = scan_flag_i & ~r_scan_d;
  assign w_any      = |r_rdy;
  assign w_complete = w_any & (r_rdy == r_en);
  assign w_tmo      = w_any & (r_tcnt == TW'(TIMEOUT));
  assign w_flush    = w_any & r_scan_d & ~scan_flag_i;
  assign w_commit   = w_complete | w_tmo | w_flush;
  assign w_acc      = ch_vld_i & r_en & {CH_NUM{scan_flag_i}};
  // an arrival in the commit cycle opens the next record
  assign w_first    = (|w_acc) & (w_commit | ~w_any);

  assign w_empty  = r_wp == r_rp;
  assign w_full   = (r_wp[AW] != r_rp[AW]) & (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_take   = ~r_out_vld | out_rdy_i;
  assign w_pop    = w_take & ~w_empty;
  assign w_bypass = w_commit & w_take & w_empty;
  assign w_push   = w_commit & ~w_bypass & (~w_full | w_pop);
  assign w_drop   = w_commit & ~w_bypass & w_full & ~w_pop;

  always_comb begin
    w_rec = '0;
    w_rec[CH_NUM-1:0] = r_en & ~r_rdy;
    w_rec[15:8] = r_seq;
    w_rec[16 +: ENC_W] = r_enc_x;
    w_rec[16 + ENC_W +: ENC_W] = r_enc_w;
    for (int k = 0; k < CH_NUM; k++)
      w_rec[CB + k * CH_W +: CH_W] = r_rdy[k] ? r_data[k] : '0;
  end

  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wp[AW-1:0]] <= w_rec;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_scan_d   <= 1'b0;
      r_en       <= '0;
      r_rdy      <= '0;
      for (int k = 0; k < CH_NUM; k++) r_data[k] <= '0;
      r_enc_w    <= '0;
      r_enc_x    <= '0;
      r_tcnt     <= '0;
      r_seq      <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_ovf      <= '0;
      r_tmo      <= '0;
    end else begin
      r_scan_d <= scan_flag_i;
      if (w_rise) r_en <= ch_en_i;
      r_rdy <= (w_commit ? '0 : r_rdy) | w_acc;
      for (int k = 0; k < CH_NUM; k++)
        if (w_acc[k]) r_data[k] <= ch_data_i[k * CH_W +: CH_W];
      if (w_first) begin
        r_enc_w <= encode_w_i[ENC_W-1:0];
        r_enc_x <= encode_x_i[ENC_W-1:0];
      end
      r_tcnt <= w_first ? TW'(1) : w_commit ? '0 : w_any ? r_tcnt + TW'(1) : r_tcnt;
      r_seq  <= w_rise ? '0 : w_commit ? r_seq + 8'd1 : r_seq;
      r_ovf  <= w_rise ? '0 : (w_drop & ~&r_ovf) ? r_ovf + 16'd1 : r_ovf;
      r_tmo  <= w_rise ? '0 : (w_commit & w_tmo & ~w_complete & ~&r_tmo) ? r_tmo + 16'd1 : r_tmo;
      r_wp   <= r_wp + {{AW{1'b0}}, w_push};
      r_rp   <= r_rp + {{AW{1'b0}}, w_pop};
      if (w_pop) begin
        r_out_vld  <= 1'b1;
        r_out_data <= r_mem[r_rp[AW-1:0]];
      end else if (w_bypass) begin
        r_out_vld  <= 1'b1;
        r_out_data <= w_rec;
      end else if (w_take) begin
        r_out_vld  <= 1'b0;
      end
    end
  end

  assign out_vld_o      = r_out_vld;
  assign out_data_o     = r_out_data;
  assign overflow_cnt_o = r_ovf;
  assign timeout_cnt_o  = r_tmo;
  assign busy_o         = w_any | ~w_empty | r_out_vld;
endmodule

// File: tb/tb_fbc_multi_cache.sv
// tb_fbc_multi_cache: directed and random stimulus checked every cycle against a record-level model
// that tracks pending arrivals by elapsed time and holds delivered records in a bounded queue.
module tb_fbc_multi_cache;
  localparam int CH_NUM = 4, CH_W = 48, ENC_W = 18, OUT_W = 256, DEPTH = 4, TIMEOUT = 16;
  localparam int CB = 16 + 2 * ENC_W;

  logic clk = 1'b0, rst_n = 1'b0, scan = 1'b0, out_rdy = 1'b0;
  logic [CH_NUM-1:0] ch_en = '0, ch_vld = '0;
  logic [CH_NUM*CH_W-1:0] ch_data = '0;
  logic [31:0] enc_w = '0, enc_x = '0;
  logic out_vld, busy;
  logic [OUT_W-1:0] out_data;
  logic [15:0] ovf_cnt, tmo_cnt;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  fbc_multi_cache #(.CH_NUM(CH_NUM), .CH_W(CH_W), .ENC_W(ENC_W), .OUT_W(OUT_W),
                    .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .scan_flag_i(scan), .ch_en_i(ch_en), .ch_vld_i(ch_vld),
    .ch_data_i(ch_data), .encode_w_i(enc_w), .encode_x_i(enc_x), .out_vld_o(out_vld),
    .out_data_o(out_data), .out_rdy_i(out_rdy), .overflow_cnt_o(ovf_cnt),
    .timeout_cnt_o(tmo_cnt), .busy_o(busy));

  logic m_prev;
  logic [CH_NUM-1:0] m_en, m_pend;
  logic [CH_W-1:0] m_data [CH_NUM];
  logic [ENC_W-1:0] m_ew, m_ex;
  int m_t, m_first, m_seq, m_ovf, m_tmo;
  logic [OUT_W-1:0] m_q [$];

  task automatic model_reset();
    m_prev = 1'b0; m_en = '0; m_pend = '0; m_t = 0; m_first = 0;
    m_seq = 0; m_ovf = 0; m_tmo = 0; m_q.delete();
  endtask

  task automatic model_step();
    logic rise, comp, tout, fl;
    logic [CH_NUM-1:0] acc;
    logic [OUT_W-1:0] rec;
    rise = scan && !m_prev;
    comp = (m_pend != 0) && (m_pend == m_en);
    tout = (m_pend != 0) && (m_t - m_first == TIMEOUT);
    fl   = (m_pend != 0) && m_prev && !scan;
    if (m_q.size() > 0 && out_rdy) void'(m_q.pop_front());
    if (comp || tout || fl) begin
      rec = '0;
      rec[7:0] = 8'(m_en & ~m_pend);
      rec[15:8] = 8'(m_seq);
      rec[16 +: ENC_W] = m_ex;
      rec[16 + ENC_W +: ENC_W] = m_ew;
      for (int k = 0; k < CH_NUM; k++)
        rec[CB + k * CH_W +: CH_W] = m_pend[k] ? m_data[k] : '0;
      if (m_q.size() < DEPTH + 1) m_q.push_back(rec);
      else if (m_ovf < 65535) m_ovf++;
      if (tout && !comp && m_tmo < 65535) m_tmo++;
      m_seq = (m_seq + 1) % 256;
      m_pend = '0;
    end
    acc = scan ? (ch_vld & m_en) : '0;
    if (acc != 0) begin
      if (m_pend == 0) begin
        m_first = m_t;
        m_ew = enc_w[ENC_W-1:0];
        m_ex = enc_x[ENC_W-1:0];
      end
      m_pend |= acc;
      for (int k = 0; k < CH_NUM; k++)
        if (acc[k]) m_data[k] = ch_data[k * CH_W +: CH_W];
    end
    if (rise) begin
      m_en = ch_en; m_seq = 0; m_ovf = 0; m_tmo = 0;
    end
    m_prev = scan;
    m_t++;
  endtask

  task automatic chk(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic compare();
    chk("out_vld", out_vld, m_q.size() > 0);
    if (m_q.size() > 0) chk("out_data", out_data, m_q[0]);
    chk("overflow_cnt", ovf_cnt, 16'(m_ovf));
    chk("timeout_cnt", tmo_cnt, 16'(m_tmo));
    chk("busy", busy, (m_pend != 0) || (m_q.size() > 0));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    #1 compare();
  endtask

  task automatic set_ch(input int k, input logic [CH_W-1:0] d);
    ch_vld[k] = 1'b1;
    ch_data[k * CH_W +: CH_W] = d;
  endtask

  task automatic wait_vld(input string tag);
    int n = 0;
    while (!out_vld && n < 20) begin cyc(); n++; end
    chk(tag, out_vld, 1'b1);
  endtask

  task automatic new_scan(input logic [CH_NUM-1:0] en);
    ch_vld = '0; scan = 1'b0;
    repeat (2) cyc();
    scan = 1'b1; ch_en = en;
    cyc();
    ch_en = ~en;
  endtask

  logic [CH_W-1:0] d0b;
  logic was_high;

  initial begin
    model_reset();
    repeat (3) cyc();
    chk("rst_data", out_data, '0);
    rst_n = 1'b1;
    out_rdy = 1'b1;

    // all four channels, strobes on cycles 10,12,13,15
    enc_w = 32'h12345; enc_x = 32'h00ABC;
    new_scan(4'hF);
    for (int c = 1; c <= 15; c++) begin
      ch_vld = '0;
      if (c == 10) set_ch(0, CH_W'({$urandom(), $urandom()}));
      if (c == 12) set_ch(1, CH_W'({$urandom(), $urandom()}));
      if (c == 13) set_ch(2, CH_W'({$urandom(), $urandom()}));
      if (c == 15) set_ch(3, CH_W'({$urandom(), $urandom()}));
      cyc();
    end
    ch_vld = '0;
    cyc();
    chk("t1_lat", out_vld, 1'b1);
    chk("t1_hdr", out_data[15:0], 16'h0000);
    chk("t1_x", out_data[16 +: ENC_W], 18'h00ABC);
    chk("t1_w", out_data[16 + ENC_W +: ENC_W], 18'h12345);
    cyc();

    // channel 2 disabled but strobing; channel 0 overwritten
    d0b = CH_W'({$urandom(), $urandom()});
    new_scan(4'b1011);
    for (int c = 1; c <= 6; c++) begin
      ch_vld = '0;
      set_ch(2, CH_W'({$urandom(), $urandom()}));
      if (c == 1) set_ch(0, CH_W'({$urandom(), $urandom()}));
      if (c == 4) set_ch(0, d0b);
      if (c == 3) set_ch(1, CH_W'({$urandom(), $urandom()}));
      if (c == 6) set_ch(3, CH_W'({$urandom(), $urandom()}));
      enc_w = $urandom(); enc_x = $urandom();
      cyc();
    end
    ch_vld = '0;
    wait_vld("t2_wait");
    chk("t2_mask", out_data[7:0], 8'h00);
    chk("t2_ch2", out_data[CB + 2 * CH_W +: CH_W], '0);
    chk("t2_ch0", out_data[CB +: CH_W], d0b);

    // channel 3 never reports: timeout commit
    new_scan(4'hF);
    set_ch(0, CH_W'({$urandom(), $urandom()})); cyc();
    ch_vld = '0; set_ch(1, CH_W'({$urandom(), $urandom()})); cyc();
    ch_vld = '0; set_ch(2, CH_W'({$urandom(), $urandom()})); cyc();
    ch_vld = '0;
    repeat (13) cyc();
    chk("t3_early", out_vld, 1'b0);
    cyc();
    chk("t3_vld", out_vld, 1'b1);
    chk("t3_mask", out_data[7:0], 8'h08);
    chk("t3_tmo", tmo_cnt, 16'd1);
    cyc();

    // backpressure: seven back-to-back records, five fit
    new_scan(4'hF);
    out_rdy = 1'b0;
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < CH_NUM; k++) set_ch(k, CH_W'({$urandom(), $urandom()}));
      cyc();
    end
    ch_vld = '0;
    repeat (3) cyc();
    chk("t4_ovf", ovf_cnt, 16'd2);
    out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_vld", out_vld, 1'b1);
      chk("t4_seq", out_data[15:8], 8'(i));
      cyc();
    end
    chk("t4_drained", out_vld, 1'b0);

    // flush with channels 0,1 pending
    set_ch(0, CH_W'({$urandom(), $urandom()}));
    set_ch(1, CH_W'({$urandom(), $urandom()}));
    cyc();
    ch_vld = '0;
    cyc();
    scan = 1'b0;
    cyc();
    chk("t5_vld", out_vld, 1'b1);
    chk("t5_mask", out_data[7:0], 8'h0C);
    chk("t5_tmo", tmo_cnt, 16'd0);
    for (int n = 0; n < 10 && busy; n++) cyc();
    chk("t5_idle", busy, 1'b0);

    // random traffic with scan toggles and backpressure
    for (int i = 0; i < 600; i++) begin
      was_high = scan;
      if (i > 580) scan = 1'b1;
      else if ($urandom_range(0, 39) == 0) scan = ~scan;
      ch_en = CH_NUM'($urandom());
      ch_vld = (was_high && scan) ? CH_NUM'($urandom() & $urandom()) : '0;
      for (int k = 0; k < CH_NUM; k++) ch_data[k * CH_W +: CH_W] = CH_W'({$urandom(), $urandom()});
      enc_w = $urandom(); enc_x = $urandom();
      out_rdy = $urandom_range(0, 3) != 0;
      cyc();
    end

    // asynchronous reset mid-burst
    #2 rst_n = 1'b0;
    #1;
    chk("rst_vld", out_vld, 1'b0);
    chk("rst_data", out_data, '0);
    chk("rst_ovf", ovf_cnt, 16'd0);
    chk("rst_tmo", tmo_cnt, 16'd0);
    chk("rst_busy", busy, 1'b0);
    model_reset();
    ch_vld = '0; scan = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      was_high = scan;
      if ($urandom_range(0, 29) == 0) scan = ~scan;
      ch_en = CH_NUM'($urandom());
      ch_vld = (was_high && scan) ? CH_NUM'($urandom() & $urandom()) : '0;
      for (int k = 0; k < CH_NUM; k++) ch_data[k * CH_W +: CH_W] = CH_W'({$urandom(), $urandom()});
      out_rdy = $urandom_range(0, 1) != 0;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
